// File: rtl/astro_pkg.sv
// Shared types, geometry constants and the inclusive span test used by the Astro Barrier engine.
package astro_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        DONE = 2'd3
    } game_state_t;

    localparam int unsigned SCREEN_W = 640;
    localparam int unsigned SCREEN_H = 480;
    localparam int unsigned CW       = 10;
    localparam int unsigned SPAN_W   = CW + 1;
    localparam int unsigned CNT_W    = 4;
    localparam int unsigned SHIP_HW  = 30;
    localparam int unsigned SHIP_HT  = 63;
    localparam int unsigned BUL_HW   = 3;
    localparam int unsigned BUL_HH   = 5;

    // p in [c-below, c+above], evaluated without subtraction so small c never wraps
    function automatic logic in_span(input logic [CW-1:0]     p,
                                     input logic [CW-1:0]     c,
                                     input logic [SPAN_W-1:0] below,
                                     input logic [SPAN_W-1:0] above);
        return (({1'b0, p} + below) >= {1'b0, c}) && ({1'b0, p} <= ({1'b0, c} + above));
    endfunction

endpackage

// File: rtl/astro_target.sv
// One bouncing target: position, direction and sticky hit flag, plus bullet and pixel box tests.
module astro_target
    import astro_pkg::*;
#(
    parameter int unsigned TGT_HALF = 10,
    parameter int unsigned TGT_STEP = 2,
    parameter int unsigned X_MIN    = 11,
    parameter int unsigned X_MAX    = 617,
    parameter logic [CW-1:0] X0     = '0,
    parameter logic [CW-1:0] Y0     = '0,
    parameter logic          DIR0   = 1'b0
) (
    input  logic          clk,
    input  logic          reset_bar,
    input  logic          load_i,
    input  logic          step_i,
    input  logic          hit_set_i,
    input  logic [CW-1:0] bul_x_i,
    input  logic [CW-1:0] bul_y_i,
    input  logic [CW-1:0] px_x_i,
    input  logic [CW-1:0] px_y_i,
    output logic [CW-1:0] x_o,
    output logic [CW-1:0] y_o,
    output logic          hit_o,
    output logic          bul_in_o_c,
    output logic          pix_in_o_c
);

    logic [CW-1:0] x_q, x_d, y_q, y_d;
    logic          dir_q, dir_d, hit_q, hit_d;

    // Bounce decision looks at the pre-tick x; the step then follows the resulting direction
    always_comb begin
        x_d   = x_q;
        y_d   = y_q;
        dir_d = dir_q;
        hit_d = hit_q;
        if (load_i) begin
            x_d   = X0;
            y_d   = Y0;
            dir_d = DIR0;
            hit_d = 1'b0;
        end else if (step_i && !hit_q) begin
            if (x_q > CW'(X_MAX)) begin
                dir_d = 1'b1;
            end else if (x_q < CW'(X_MIN)) begin
                dir_d = 1'b0;
            end
            x_d = dir_d ? (x_q - CW'(TGT_STEP)) : (x_q + CW'(TGT_STEP));
            if (hit_set_i) begin
                hit_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_bar) begin
        if (!reset_bar) begin
            x_q   <= X0;
            y_q   <= Y0;
            dir_q <= DIR0;
            hit_q <= 1'b0;
        end else begin
            x_q   <= x_d;
            y_q   <= y_d;
            dir_q <= dir_d;
            hit_q <= hit_d;
        end
    end

    assign x_o   = x_q;
    assign y_o   = y_q;
    assign hit_o = hit_q;

    // Hit targets are transparent to the bullet but still drawn (as dead)
    assign bul_in_o_c = !hit_q
                      && in_span(bul_x_i, x_q, SPAN_W'(TGT_HALF), SPAN_W'(TGT_HALF))
                      && in_span(bul_y_i, y_q, SPAN_W'(TGT_HALF), SPAN_W'(TGT_HALF));
    assign pix_in_o_c = in_span(px_x_i, x_q, SPAN_W'(TGT_HALF), SPAN_W'(TGT_HALF))
                      && in_span(px_y_i, y_q, SPAN_W'(TGT_HALF), SPAN_W'(TGT_HALF));

endmodule

// File: rtl/astro_target_engine.sv
// Astro Barrier game-state engine: game FSM, ship, bullet, hit priority/counter and pixel flags.
module astro_target_engine
    import astro_pkg::*;
#(
    parameter int unsigned NUM_TGT   = 3,
    parameter int unsigned TGT_HALF  = 10,
    parameter int unsigned TGT_STEP  = 2,
    parameter int unsigned X_MIN     = 11,
    parameter int unsigned X_MAX     = 617,
    parameter int unsigned SHIP_STEP = 5,
    parameter int unsigned SHIP_MIN  = 30,
    parameter int unsigned SHIP_MAX  = 610,
    parameter int unsigned SHIP_X0   = 400,
    parameter int unsigned SHIP_Y    = 448,
    parameter int unsigned BUL_Y0    = 435,
    parameter int unsigned BUL_STEP  = 10,
    parameter logic [NUM_TGT*CW-1:0] TGT_X0   = {10'd500, 10'd320, 10'd100},
    parameter logic [NUM_TGT*CW-1:0] TGT_Y0   = {10'd200, 10'd140, 10'd80},
    parameter logic [NUM_TGT-1:0]    TGT_DIR0 = 3'b010
) (
    input  logic                    clk,
    input  logic                    reset_bar,
    input  logic                    tick,
    input  logic                    start,
    input  logic                    btn_left,
    input  logic                    btn_right,
    input  logic                    btn_fire,
    input  logic [CW-1:0]           px_x,
    input  logic [CW-1:0]           px_y,
    output logic [1:0]              state,
    output logic [CW-1:0]           ship_x,
    output logic                    bul_act,
    output logic [CW-1:0]           bul_x,
    output logic [CW-1:0]           bul_y,
    output logic [NUM_TGT*CW-1:0]   tgt_x,
    output logic [NUM_TGT*CW-1:0]   tgt_y,
    output logic [NUM_TGT-1:0]      tgt_hit,
    output logic [CNT_W-1:0]        hit_cnt,
    output logic                    all_hit,
    output logic                    pix_ship,
    output logic                    pix_live,
    output logic                    pix_dead,
    output logic                    pix_bul
);

    game_state_t      state_q, state_d;
    logic [CW-1:0]    ship_x_q, ship_x_d, bul_x_q, bul_x_d, bul_y_q, bul_y_d;
    logic             bul_act_q, bul_act_d, all_hit_q, all_hit_d;
    logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d;
    logic             pix_ship_q, pix_live_q, pix_dead_q, pix_bul_q;
    logic             load_c, step_c, any_hit_c;
    logic [NUM_TGT-1:0] bul_in_c, pix_in_c, hit_sel_c;

    assign load_c = (state_q == DONE) && start;
    assign step_c = (state_q == PLAY) && tick;

    for (genvar i = 0; i < NUM_TGT; i++) begin : g_tgt
        astro_target #(
            .TGT_HALF (TGT_HALF),
            .TGT_STEP (TGT_STEP),
            .X_MIN    (X_MIN),
            .X_MAX    (X_MAX),
            .X0       (TGT_X0[CW*i +: CW]),
            .Y0       (TGT_Y0[CW*i +: CW]),
            .DIR0     (TGT_DIR0[i])
        ) u_tgt (
            .clk        (clk),
            .reset_bar  (reset_bar),
            .load_i     (load_c),
            .step_i     (step_c),
            .hit_set_i  (hit_sel_c[i]),
            .bul_x_i    (bul_x_q),
            .bul_y_i    (bul_y_q),
            .px_x_i     (px_x),
            .px_y_i     (px_y),
            .x_o        (tgt_x[CW*i +: CW]),
            .y_o        (tgt_y[CW*i +: CW]),
            .hit_o      (tgt_hit[i]),
            .bul_in_o_c (bul_in_c[i]),
            .pix_in_o_c (pix_in_c[i])
        );
    end

    // Lowest-index overlapping unhit target takes the bullet
    always_comb begin
        hit_sel_c = '0;
        any_hit_c = 1'b0;
        for (int i = 0; i < NUM_TGT; i++) begin
            if (step_c && bul_act_q && bul_in_c[i] && !any_hit_c) begin
                hit_sel_c[i] = 1'b1;
                any_hit_c    = 1'b1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        ship_x_d  = ship_x_q;
        bul_act_d = bul_act_q;
        bul_x_d   = bul_x_q;
        bul_y_d   = bul_y_q;
        hit_cnt_d = hit_cnt_q;
        all_hit_d = all_hit_q;
        unique case (state_q)
            IDLE:    if (start)     state_d = PLAY;
            PLAY:    if (all_hit_q) state_d = DONE;
            DONE:    if (start)     state_d = IDLE;
            default:                state_d = IDLE;
        endcase
        if (load_c) begin
            ship_x_d  = CW'(SHIP_X0);
            bul_act_d = 1'b0;
            bul_x_d   = '0;
            bul_y_d   = '0;
            hit_cnt_d = '0;
            all_hit_d = 1'b0;
        end else if (step_c) begin
            if (btn_left && !btn_right && !btn_fire && (ship_x_q > CW'(SHIP_MIN))) begin
                ship_x_d = ship_x_q - CW'(SHIP_STEP);
            end else if (btn_right && !btn_left && !btn_fire && (ship_x_q < CW'(SHIP_MAX))) begin
                ship_x_d = ship_x_q + CW'(SHIP_STEP);
            end
            if (bul_act_q) begin
                if (bul_y_q < CW'(BUL_STEP)) begin
                    bul_act_d = 1'b0;
                end else begin
                    bul_y_d = bul_y_q - CW'(BUL_STEP);
                end
                if (any_hit_c) begin
                    bul_act_d = 1'b0;
                    hit_cnt_d = hit_cnt_q + CNT_W'(1);
                end
            end else if (btn_fire && !btn_left && !btn_right) begin
                bul_act_d = 1'b1;
                bul_x_d   = ship_x_q;
                bul_y_d   = CW'(BUL_Y0);
            end
            all_hit_d = &(tgt_hit | hit_sel_c);
        end
    end

    always_ff @(posedge clk or negedge reset_bar) begin
        if (!reset_bar) begin
            state_q   <= IDLE;
            ship_x_q  <= CW'(SHIP_X0);
            bul_act_q <= 1'b0;
            bul_x_q   <= '0;
            bul_y_q   <= '0;
            hit_cnt_q <= '0;
            all_hit_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ship_x_q  <= ship_x_d;
            bul_act_q <= bul_act_d;
            bul_x_q   <= bul_x_d;
            bul_y_q   <= bul_y_d;
            hit_cnt_q <= hit_cnt_d;
            all_hit_q <= all_hit_d;
        end
    end

    // Pixel flags lag px_x/px_y by exactly one clock in every game state
    always_ff @(posedge clk or negedge reset_bar) begin
        if (!reset_bar) begin
            pix_ship_q <= 1'b0;
            pix_live_q <= 1'b0;
            pix_dead_q <= 1'b0;
            pix_bul_q  <= 1'b0;
        end else begin
            pix_ship_q <= in_span(px_x, ship_x_q, SPAN_W'(SHIP_HW), SPAN_W'(SHIP_HW))
                       && in_span(px_y, CW'(SHIP_Y), SPAN_W'(0), SPAN_W'(SHIP_HT));
            pix_live_q <= |(pix_in_c & ~tgt_hit);
            pix_dead_q <= |(pix_in_c & tgt_hit);
            pix_bul_q  <= bul_act_q
                       && in_span(px_y, bul_y_q, SPAN_W'(BUL_HH), SPAN_W'(BUL_HH))
                       && in_span(px_x, bul_x_q, SPAN_W'(BUL_HW), SPAN_W'(BUL_HW));
        end
    end

    assign state    = state_q;
    assign ship_x   = ship_x_q;
    assign bul_act  = bul_act_q;
    assign bul_x    = bul_x_q;
    assign bul_y    = bul_y_q;
    assign hit_cnt  = hit_cnt_q;
    assign all_hit  = all_hit_q;
    assign pix_ship = pix_ship_q;
    assign pix_live = pix_live_q;
    assign pix_dead = pix_dead_q;
    assign pix_bul  = pix_bul_q;

endmodule
